// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin instruction/data arbiter for one shared byte-laned memory
// Grants one port per cycle, checks alignment, routes registered read data and counts grants.
module mem_arbiter #(
   parameter int COUNT_W = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               i_req,
   input  logic [31:0]        i_addr,
   input  logic [3:0]         i_width,
   output logic               i_gnt,
   output logic               i_rvalid,
   output logic [31:0]        i_rdata,
   output logic               i_err,
   input  logic               d_req,
   input  logic               d_write,
   input  logic [31:0]        d_addr,
   input  logic [3:0]         d_width,
   input  logic [31:0]        d_wdata,
   output logic               d_gnt,
   output logic               d_rvalid,
   output logic [31:0]        d_rdata,
   output logic               d_err,
   output logic [31:0]        m_address,
   output logic [3:0]         m_width,
   output logic               m_write_en,
   output logic [31:0]        m_data_in,
   input  logic [31:0]        m_data_out,
   output logic [COUNT_W-1:0] i_count,
   output logic [COUNT_W-1:0] d_count
);

   typedef enum logic {PORT_I = 1'b0, PORT_D = 1'b1} port_t;

   port_t              last_q;
   port_t              resp_port_q;
   logic               resp_pend_q;
   logic               resp_err_q;
   logic [COUNT_W-1:0] i_cnt_q;
   logic [COUNT_W-1:0] d_cnt_q;
   logic               sel_legal;

   function automatic logic is_legal(input logic [31:0] addr, input logic [3:0] width);
      case (width)
         4'd1:    return 1'b1;
         4'd2:    return ~addr[0];
         4'd4:    return (addr[1:0] == 2'b00);
         default: return 1'b0;
      endcase
   endfunction

   always_comb begin
      i_gnt      = 1'b0;
      d_gnt      = 1'b0;
      sel_legal  = 1'b0;
      m_address  = '0;
      m_width    = '0;
      m_write_en = 1'b0;
      m_data_in  = '0;
      if (reset) begin
         if (i_req && (!d_req || last_q == PORT_D))
            i_gnt = 1'b1;
         else if (d_req)
            d_gnt = 1'b1;
      end
      // Illegal accesses still take the grant but leave the memory untouched.
      if (i_gnt) begin
         sel_legal = is_legal(i_addr, i_width);
         m_address = i_addr;
         m_width   = sel_legal ? i_width : 4'd0;
      end else if (d_gnt) begin
         sel_legal  = is_legal(d_addr, d_width);
         m_address  = d_addr;
         m_width    = sel_legal ? d_width : 4'd0;
         m_write_en = sel_legal && d_write;
         m_data_in  = d_wdata;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         last_q      <= PORT_D;
         resp_port_q <= PORT_I;
         resp_pend_q <= 1'b0;
         resp_err_q  <= 1'b0;
         i_cnt_q     <= '0;
         d_cnt_q     <= '0;
      end else begin
         resp_pend_q <= i_gnt || (d_gnt && (!d_write || !sel_legal));
         resp_port_q <= d_gnt ? PORT_D : PORT_I;
         resp_err_q  <= !sel_legal;
         if (i_gnt) begin
            last_q <= PORT_I;
            if (i_cnt_q != '1)
               i_cnt_q <= i_cnt_q + COUNT_W'(1);
         end
         if (d_gnt) begin
            last_q <= PORT_D;
            if (d_cnt_q != '1)
               d_cnt_q <= d_cnt_q + COUNT_W'(1);
         end
      end
   end

   // Response outputs are gated by reset so a read granted just before reset is dropped.
   assign i_rvalid = reset && resp_pend_q && (resp_port_q == PORT_I);
   assign d_rvalid = reset && resp_pend_q && (resp_port_q == PORT_D);
   assign i_err    = i_rvalid && resp_err_q;
   assign d_err    = d_rvalid && resp_err_q;
   assign i_rdata  = (i_rvalid && !resp_err_q) ? m_data_out : 32'd0;
   assign d_rdata  = (d_rvalid && !resp_err_q) ? m_data_out : 32'd0;
   assign i_count  = reset ? i_cnt_q : '0;
   assign d_count  = reset ? d_cnt_q : '0;

endmodule
